uart_mem_target: RTL and testbench
==================================

// Module: uart_mem_target
// PURPOSE
//   Memory-mapped register-bank target that sits directly downstream of uart_ip_memory_mapped.
//   It consumes the UART bridge's write strobes, serves its read requests, and drives mem_rdata/mem_rdy.
//   It replaces the tied-off rdata/rdy stub in the board debug top.
//   It also exports the last committed write so the 7-segment debug display can show it.
// PARAMETERS
//   NUM_BYTES_DATA     4             data width in bytes (DW = 8*NUM_BYTES_DATA)
//   NUM_BYTES_ADDRESS  1             address width in bytes (AW = 8*NUM_BYTES_ADDRESS)
//   DEPTH              16            number of DW-bit words; 1 <= DEPTH <= 2**AW
//   READ_LATENCY       2             cycles from accepted read to rdata valid; must be >= 1
//   OOR_DATA           32'hDEADBEEF  rdata returned for out-of-range reads, truncated/zero-extended to DW
// PORTS
//   clk             in   1       system clock, rising edge
//   arst_n          in   1       asynchronous active-low reset
//   mem_we          in   1       write strobe, 1-cycle pulse
//   mem_wdata       in   DW      write data, valid with mem_we
//   mem_waddr       in   AW      write word address, valid with mem_we
//   mem_re          in   1       read strobe, 1-cycle pulse
//   mem_raddr       in   AW      read word address, valid with mem_re
//   mem_rdata       out  DW      read data, valid while mem_rdy=1 after a read
//   mem_rdy         out  1       1 = idle/accepting and rdata valid; 0 = read in flight
//   last_wr         out  DW+AW   {wdata,waddr} of the most recent committed write
//   drop_cnt        out  8       saturating count of requests dropped while busy
// BEHAVIOUR
//   Reset (arst_n=0, async): FSM=IDLE, mem_rdy=1, mem_rdata=0, last_wr=0, drop_cnt=0, all DEPTH words=0.
//   FSM states:
//     IDLE: mem_rdy=1.
//       mem_re=1 -> capture raddr, load cnt=READ_LATENCY-1, go to BUSY.
//       mem_rdy drops on the next cycle.
//     BUSY: mem_rdy=0; cnt decrements each cycle.
//       At cnt==0: load mem_rdata from captured address, go to IDLE.
//       mem_rdy=1 and rdata are visible READ_LATENCY cycles after the re cycle.
//   Writes are accepted only in IDLE.
//     On mem_we, word[waddr] and last_wr update at the next edge (1-cycle latency).
//     mem_rdy stays 1 during writes.
//   mem_we and mem_re in the same IDLE cycle: both accepted, write-first.
//     A read of the same address returns the new wdata.
//   Writes to the captured read address are impossible while BUSY (dropped).
//     Read data is therefore stable from capture to return.
//   Any mem_we or mem_re while BUSY is ignored and increments drop_cnt.
//     A simultaneous we+re while BUSY counts 2. drop_cnt saturates at 255 and never wraps.
//   Out-of-range address (addr >= DEPTH):
//     write: no state change except last_wr, which still updates.
//     read: normal latency and handshake; returns OOR_DATA.
//   mem_rdata holds its value in IDLE until the next read completes; writes never alter it.
//   Reset asserted mid-read aborts the read: IDLE, rdy=1, rdata=0, memory cleared.
// TESTING
//   1. Write 32'hFCD09A23 @8'h05, then read 8'h05 (LAT=2).
//      -> rdy low 2 cycles; rdata=FCD09A23; last_wr=40'hFCD09A2305.
//   2. Same-cycle we=1 wdata=32'h12345678 @8'h03 and re @8'h03, word previously 0.
//      -> rdata=12345678 after 2 cycles.
//   3. re @8'h01, then we @8'h01 and re @8'h02 on the next (BUSY) cycle.
//      -> both dropped; drop_cnt=2; word[1] unchanged.
//   4. Read @8'h20 with DEPTH=16.
//      -> rdata=DEADBEEF after LAT.
//      Write @8'h20 -> memory unchanged; last_wr updated.
//   5. arst_n pulsed low 1 cycle after re accepted.
//      -> rdy=1 immediately; rdata=0; a read of any address returns 0.
//   6. 300 requests issued while BUSY across multiple reads.
//      -> drop_cnt=255, no wrap; READ_LATENCY=1 variant -> rdy low exactly 1 cycle.

Source files
------------

// File: rtl/uart_mem_target.sv
// Register-bank target behind the UART memory-mapped bridge: fixed-latency reads,
// single-cycle writes, last-write export for the debug display and a saturating drop counter.
module uart_mem_target #(
  parameter int          NUM_BYTES_DATA    = 4,
  parameter int          NUM_BYTES_ADDRESS = 1,
  parameter int          DEPTH             = 16,
  parameter int          READ_LATENCY      = 2,
  parameter logic [31:0] OOR_DATA          = 32'hDEADBEEF
) (
  input  logic                                          clk,
  input  logic                                          arst_n,
  input  logic                                          mem_we,
  input  logic [8*NUM_BYTES_DATA-1:0]                   mem_wdata,
  input  logic [8*NUM_BYTES_ADDRESS-1:0]                mem_waddr,
  input  logic                                          mem_re,
  input  logic [8*NUM_BYTES_ADDRESS-1:0]                mem_raddr,
  output logic [8*NUM_BYTES_DATA-1:0]                   mem_rdata,
  output logic                                          mem_rdy,
  output logic [8*NUM_BYTES_DATA+8*NUM_BYTES_ADDRESS-1:0] last_wr,
  output logic [7:0]                                    drop_cnt
);

  localparam int DW = 8 * NUM_BYTES_DATA;
  localparam int AW = 8 * NUM_BYTES_ADDRESS;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  localparam logic [DW-1:0] OOR_WORD = DW'(OOR_DATA);
  localparam logic [CW-1:0] CNT_INIT = CW'(READ_LATENCY - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [AW-1:0] raddr_q;
  logic [DW-1:0] mem [DEPTH];

  logic          wr_hit;
  logic [1:0]    drop_inc;
  logic [8:0]    drop_sum;
  logic [DW-1:0] rd_word;

  function automatic logic in_range(input logic [AW-1:0] addr);
    return {1'b0, addr} < (AW+1)'(DEPTH);
  endfunction

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    wr_hit   = 1'b0;
    drop_inc = 2'd0;
    rd_word  = OOR_WORD;
    if (state == IDLE) begin
      wr_hit = mem_we && in_range(mem_waddr);
    end else begin
      drop_inc = {1'b0, mem_we} + {1'b0, mem_re};
    end
    if (in_range(raddr_q)) begin
      rd_word = mem[raddr_q[IW-1:0]];
    end
  end

  assign drop_sum = {1'b0, drop_cnt} + {7'b0, drop_inc};

  // NOTE: the word array is cleared by reset because a reset must read back as all zeros;
  // that rules out block-RAM inference, which is acceptable for a small debug bank.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_hit) begin
      mem[mem_waddr[IW-1:0]] <= mem_wdata;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      raddr_q   <= '0;
      mem_rdy   <= 1'b1;
      mem_rdata <= '0;
      last_wr   <= '0;
      drop_cnt  <= '0;
    end else begin
      drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
      case (state)
        IDLE: begin
          if (mem_we) begin
            last_wr <= {mem_wdata, mem_waddr};
          end
          // The word is fetched at completion, so a same-cycle write is already visible.
          if (mem_re) begin
            raddr_q <= mem_raddr;
            cnt     <= CNT_INIT;
            mem_rdy <= 1'b0;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            mem_rdata <= rd_word;
            mem_rdy   <= 1'b1;
            state     <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_mem_target.sv
// Directed bench for uart_mem_target: per-cycle vector table plus hand sequences for
// reset abort, drop-counter saturation and the single-cycle-latency variant.
module tb_uart_mem_target;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        mem_we, mem_re;
  logic [31:0] mem_wdata;
  logic [7:0]  mem_waddr, mem_raddr;
  logic [31:0] mem_rdata;
  logic        mem_rdy;
  logic [39:0] last_wr;
  logic [7:0]  drop_cnt;

  logic        we1, re1;
  logic [31:0] wdata1;
  logic [7:0]  waddr1, raddr1;
  logic [31:0] rdata1;
  logic        rdy1;
  logic [39:0] last1;
  logic [7:0]  drop1;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  uart_mem_target dut (
    .clk(clk), .arst_n(arst_n),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_waddr(mem_waddr),
    .mem_re(mem_re), .mem_raddr(mem_raddr),
    .mem_rdata(mem_rdata), .mem_rdy(mem_rdy),
    .last_wr(last_wr), .drop_cnt(drop_cnt)
  );

  uart_mem_target #(.READ_LATENCY(1)) dut1 (
    .clk(clk), .arst_n(arst_n),
    .mem_we(we1), .mem_wdata(wdata1), .mem_waddr(waddr1),
    .mem_re(re1), .mem_raddr(raddr1),
    .mem_rdata(rdata1), .mem_rdy(rdy1),
    .last_wr(last1), .drop_cnt(drop1)
  );

  typedef struct {
    logic        we;
    logic [7:0]  waddr;
    logic [31:0] wdata;
    logic        re;
    logic [7:0]  raddr;
    logic        rdy;
    logic [31:0] rdata;
    logic [39:0] last;
    logic [7:0]  drop;
  } vec_t;

  vec_t vecs [24];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_we = 1'b0; mem_re = 1'b0;
    mem_wdata = '0; mem_waddr = '0; mem_raddr = '0;
  endtask

  // Read on the LAT=2 instance: rdy low for two cycles, then data.
  task automatic do_read(input logic [7:0] addr, input logic [31:0] exp, input string name);
    mem_re = 1'b1; mem_raddr = addr;
    tick();
    mem_re = 1'b0;
    check({name, " rdy0a"}, 64'(mem_rdy), 64'(1'b0));
    tick();
    check({name, " rdy0b"}, 64'(mem_rdy), 64'(1'b0));
    tick();
    check({name, " rdy1"}, 64'(mem_rdy), 64'(1'b1));
    check({name, " rdata"}, 64'(mem_rdata), 64'(exp));
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{1'b1, 8'h05, 32'hFCD09A23, 1'b0, 8'h00, 1'b1, 32'h00000000, 40'hFCD09A2305, 8'd0};
    vecs[1]  = '{1'b0, 8'h00, 32'h00000000, 1'b1, 8'h05, 1'b0, 32'h00000000, 40'hFCD09A2305, 8'd0};
    vecs[2]  = '{1'b0, 8'h00, 32'h00000000, 1'b0, 8'h00, 1'b0, 32'h00000000, 40'hFCD09A2305, 8'd0};
    vecs[3]  = '{1'b0, 8'h00, 32'h00000000, 1'b0, 8'h00, 1'b1, 32'hFCD09A23, 40'hFCD09A2305, 8'd0};
    vecs[4]  = '{1'b1, 8'h03, 32'h12345678, 1'b1, 8'h03, 1'b0, 32'hFCD09A23, 40'h1234567803, 8'd0};
    vecs[5]  = '{1'b0, 8'h00, 32'h00000000, 1'b0, 8'h00, 1'b0, 32'hFCD09A23, 40'h1234567803, 8'd0};
    vecs[6]  = '{1'b0, 8'h00, 32'h00000000, 1'b0, 8'h00, 1'b1, 32'h12345678, 40'h1234567803, 8'd0};
    vecs[7]  = '{1'b0, 8'h00, 32'h00000000, 1'b1, 8'h01, 1'b0, 32'h12345678, 40'h1234567803, 8'd0};
    vecs[8]  = '{1'b1, 8'h01, 32'hAAAA5555, 1'b1, 8'h02, 1'b0, 32'h12345678, 40'h1234567803, 8'd2};
    vecs[9]  = '{1'b0, 8'h00, 32'h00000000, 1'b0, 8'h00, 1'b1, 32'h00000000, 40'h1234567803, 8'd2};
    vecs[10] = '{1'b0, 8'h00, 32'h00000000, 1'b1, 8'h20, 1'b0, 32'h00000000, 40'h1234567803, 8'd2};
    vecs[11] = '{1'b0, 8'h00, 32'h00000000, 1'b0, 8'h00, 1'b0, 32'h00000000, 40'h1234567803, 8'd2};
    vecs[12] = '{1'b0, 8'h00, 32'h00000000, 1'b0, 8'h00, 1'b1, 32'hDEADBEEF, 40'h1234567803, 8'd2};
    vecs[13] = '{1'b1, 8'h20, 32'h11112222, 1'b0, 8'h00, 1'b1, 32'hDEADBEEF, 40'h1111222220, 8'd2};
    vecs[14] = '{1'b0, 8'h00, 32'h00000000, 1'b1, 8'h00, 1'b0, 32'hDEADBEEF, 40'h1111222220, 8'd2};
    vecs[15] = '{1'b0, 8'h00, 32'h00000000, 1'b0, 8'h00, 1'b0, 32'hDEADBEEF, 40'h1111222220, 8'd2};
    vecs[16] = '{1'b0, 8'h00, 32'h00000000, 1'b0, 8'h00, 1'b1, 32'h00000000, 40'h1111222220, 8'd2};
    vecs[17] = '{1'b1, 8'h0F, 32'h0BADF00D, 1'b0, 8'h00, 1'b1, 32'h00000000, 40'h0BADF00D0F, 8'd2};
    vecs[18] = '{1'b0, 8'h00, 32'h00000000, 1'b1, 8'h0F, 1'b0, 32'h00000000, 40'h0BADF00D0F, 8'd2};
    vecs[19] = '{1'b0, 8'h00, 32'h00000000, 1'b0, 8'h00, 1'b0, 32'h00000000, 40'h0BADF00D0F, 8'd2};
    vecs[20] = '{1'b0, 8'h00, 32'h00000000, 1'b0, 8'h00, 1'b1, 32'h0BADF00D, 40'h0BADF00D0F, 8'd2};
    vecs[21] = '{1'b0, 8'h00, 32'h00000000, 1'b1, 8'h10, 1'b0, 32'h0BADF00D, 40'h0BADF00D0F, 8'd2};
    vecs[22] = '{1'b0, 8'h00, 32'h00000000, 1'b0, 8'h00, 1'b0, 32'h0BADF00D, 40'h0BADF00D0F, 8'd2};
    vecs[23] = '{1'b0, 8'h00, 32'h00000000, 1'b0, 8'h00, 1'b1, 32'hDEADBEEF, 40'h0BADF00D0F, 8'd2};

    idle_inputs();
    we1 = 1'b0; re1 = 1'b0; wdata1 = '0; waddr1 = '0; raddr1 = '0;
    arst_n = 1'b0;
    tick();
    tick();
    check("reset rdy", 64'(mem_rdy), 64'(1'b1));
    check("reset rdata", 64'(mem_rdata), 64'(0));
    check("reset last_wr", 64'(last_wr), 64'(0));
    check("reset drop_cnt", 64'(drop_cnt), 64'(0));
    arst_n = 1'b1;
    tick();

    for (int i = 0; i < 24; i++) begin
      mem_we = vecs[i].we; mem_waddr = vecs[i].waddr; mem_wdata = vecs[i].wdata;
      mem_re = vecs[i].re; mem_raddr = vecs[i].raddr;
      tick();
      check($sformatf("vec%0d rdy", i), 64'(mem_rdy), 64'(vecs[i].rdy));
      check($sformatf("vec%0d rdata", i), 64'(mem_rdata), 64'(vecs[i].rdata));
      check($sformatf("vec%0d last_wr", i), 64'(last_wr), 64'(vecs[i].last));
      check($sformatf("vec%0d drop_cnt", i), 64'(drop_cnt), 64'(vecs[i].drop));
    end
    idle_inputs();

    // Reset asserted one cycle into a read aborts it and clears everything.
    mem_re = 1'b1; mem_raddr = 8'h05;
    tick();
    mem_re = 1'b0;
    check("abort rdy busy", 64'(mem_rdy), 64'(1'b0));
    arst_n = 1'b0;
    #1;
    check("abort rdy async", 64'(mem_rdy), 64'(1'b1));
    check("abort rdata", 64'(mem_rdata), 64'(0));
    check("abort last_wr", 64'(last_wr), 64'(0));
    check("abort drop_cnt", 64'(drop_cnt), 64'(0));
    tick();
    arst_n = 1'b1;
    tick();
    do_read(8'h05, 32'h0, "post-reset rd05");
    do_read(8'h0F, 32'h0, "post-reset rd0F");

    // 75 reads x 2 busy cycles x (we+re) = 300 dropped requests.
    for (int r = 0; r < 75; r++) begin
      mem_re = 1'b1; mem_raddr = 8'h01;
      tick();
      mem_we = 1'b1; mem_waddr = 8'h01; mem_wdata = 32'hFFFFFFFF;
      tick();
      if (r == 63) check("sat drop 254", 64'(drop_cnt), 64'(254));
      tick();
      if (r == 62) check("sat drop 252", 64'(drop_cnt), 64'(252));
      if (r == 63) check("sat drop 255", 64'(drop_cnt), 64'(255));
      idle_inputs();
    end
    check("sat drop final", 64'(drop_cnt), 64'(255));
    check("sat rdy idle", 64'(mem_rdy), 64'(1'b1));
    do_read(8'h01, 32'h0, "busy writes dropped rd01");

    // Single-cycle latency instance.
    we1 = 1'b1; waddr1 = 8'h02; wdata1 = 32'hC0FFEE11;
    tick();
    we1 = 1'b0;
    check("lat1 last_wr", 64'(last1), 64'(40'hC0FFEE1102));
    re1 = 1'b1; raddr1 = 8'h02;
    tick();
    check("lat1 rdy low", 64'(rdy1), 64'(1'b0));
    raddr1 = 8'h03;
    tick();
    re1 = 1'b0;
    check("lat1 rdy back", 64'(rdy1), 64'(1'b1));
    check("lat1 rdata", 64'(rdata1), 64'(32'hC0FFEE11));
    check("lat1 drop", 64'(drop1), 64'(1));
    tick();
    check("lat1 rdy stays", 64'(rdy1), 64'(1'b1));
    check("lat1 rdata hold", 64'(rdata1), 64'(32'hC0FFEE11));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
